// File: rtl/vga_line_scheduler.sv
// Line sequencer for the 1-bit VGA DMA: programs one line per transfer from a
// CPU-set frame base, paces on DMA FIFO level, and swaps buffers at frame end.
//
// state      | meaning
// IDLE       | disabled, no bus activity
// WAIT_VSYNC | enabled, waiting for frame-start pulse
// RD_LVL     | reading DMA WRUSEDW until there is room for one line
// WR_ADDR    | writing line source address
// WR_LEN     | writing line length
// WR_CTRL    | writing DMA mode bit
// WR_START   | kicking the DMA
// WAIT_IRQ   | waiting for line-done irq or timeout
// CLR_IRQ    | clearing DMA status
// NEXT       | stepping to the next line or closing the frame
module vga_line_scheduler #(
  parameter int LINES      = 480,
  parameter int LINE_BYTES = 80,
  parameter int STRIDE     = 80,
  parameter int FIFO_DEPTH = 4096,
  parameter int TIMEOUT    = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  avs_ctl_address,
  input  logic        avs_ctl_write,
  input  logic        avs_ctl_read,
  input  logic [31:0] avs_ctl_writedata,
  output logic [31:0] avs_ctl_readdata,
  output logic [2:0]  avm_cfg_address,
  output logic        avm_cfg_write,
  output logic        avm_cfg_read,
  output logic [31:0] avm_cfg_writedata,
  input  logic [31:0] avm_cfg_readdata,
  input  logic        avm_cfg_waitrequest,
  input  logic        dma_irq,
  input  logic        vsync_pulse,
  output logic        frame_irq
);

  typedef enum logic [3:0] {
    IDLE, WAIT_VSYNC, RD_LVL, WR_ADDR, WR_LEN, WR_CTRL, WR_START, WAIT_IRQ, CLR_IRQ, NEXT
  } state_t;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMR_LOAD   = TW'(TIMEOUT - 1);
  localparam logic [15:0]   LAST_LINE  = 16'(LINES - 1);
  localparam logic [32:0]   LVL_LIMIT  = 33'(FIFO_DEPTH - 1);
  localparam logic [32:0]   LINE_HALF  = 33'(LINE_BYTES / 2);
  localparam logic [31:0]   STRIDE32   = 32'(STRIDE);
  // The DMA moves LONGTH/2 + 1 halfwords, hence the -2.
  localparam logic [31:0]   LEN_WORD   = 32'(LINE_BYTES - 2);

  state_t        state_q, state_d;
  logic [1:0]    ctrl_q, ctrl_d;
  logic [31:0]   front_q, front_d;
  logic [31:0]   back_q, back_d;
  logic          pending_q, pending_d;
  logic          done_q, done_d;
  logic          tmo_q, tmo_d;
  logic [15:0]   line_q, line_d;
  logic [31:0]   addr_q, addr_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          fixed_q, fixed_d;
  logic          frame_irq_q, frame_irq_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          back_wr;
  logic          bus_done;
  logic          last_line;
  logic [32:0]   lvl_sum;

  assign back_wr   = avs_ctl_write && (avs_ctl_address == 2'd2);
  assign bus_done  = !avm_cfg_waitrequest;
  assign last_line = (line_q == LAST_LINE);
  assign lvl_sum   = {1'b0, avm_cfg_readdata} + LINE_HALF;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ctrl_q      <= '0;
      front_q     <= '0;
      back_q      <= '0;
      pending_q   <= 1'b0;
      done_q      <= 1'b0;
      tmo_q       <= 1'b0;
      line_q      <= '0;
      addr_q      <= '0;
      timer_q     <= '0;
      fixed_q     <= 1'b0;
      frame_irq_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      front_q     <= front_d;
      back_q      <= back_d;
      pending_q   <= pending_d;
      done_q      <= done_d;
      tmo_q       <= tmo_d;
      line_q      <= line_d;
      addr_q      <= addr_d;
      timer_q     <= timer_d;
      fixed_q     <= fixed_d;
      frame_irq_q <= frame_irq_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    front_d     = front_q;
    back_d      = back_q;
    pending_d   = pending_q;
    done_d      = done_q;
    tmo_d       = tmo_q;
    line_d      = line_q;
    addr_d      = addr_q;
    timer_d     = timer_q;
    fixed_d     = fixed_q;
    frame_irq_d = 1'b0;
    rdata_d     = rdata_q;

    if (avs_ctl_write) begin
      case (avs_ctl_address)
        2'd0: ctrl_d = avs_ctl_writedata[1:0];
        2'd2: begin
          back_d    = avs_ctl_writedata;
          pending_d = 1'b1;
        end
        2'd3: begin
          if (avs_ctl_writedata[0]) done_d = 1'b0;
          if (avs_ctl_writedata[1]) tmo_d  = 1'b0;
        end
        default: ;
      endcase
    end

    if (avs_ctl_read) begin
      case (avs_ctl_address)
        2'd0:    rdata_d = {30'b0, ctrl_q};
        2'd1:    rdata_d = front_q;
        2'd2:    rdata_d = back_q;
        default: rdata_d = {6'b0, line_q[9:0], 13'b0, pending_q, tmo_q, done_q};
      endcase
    end

    // FSM updates come after the CPU clears so a same-cycle set wins.
    case (state_q)
      IDLE: if (ctrl_q[0]) state_d = WAIT_VSYNC;
      WAIT_VSYNC: begin
        if (!ctrl_q[0]) begin
          state_d = IDLE;
        end else if (vsync_pulse) begin
          state_d = RD_LVL;
          line_d  = '0;
          addr_d  = front_q;
        end
      end
      RD_LVL: begin
        if (bus_done && (lvl_sum <= LVL_LIMIT)) begin
          state_d = WR_ADDR;
          fixed_d = ctrl_q[1];
        end
      end
      WR_ADDR:  if (bus_done) state_d = WR_LEN;
      WR_LEN:   if (bus_done) state_d = WR_CTRL;
      WR_CTRL:  if (bus_done) state_d = WR_START;
      WR_START: begin
        if (bus_done) begin
          state_d = WAIT_IRQ;
          timer_d = TMR_LOAD;
        end
      end
      WAIT_IRQ: begin
        if (dma_irq) begin
          state_d = CLR_IRQ;
        end else if (timer_q == '0) begin
          tmo_d   = 1'b1;
          state_d = CLR_IRQ;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      CLR_IRQ: begin
        if (bus_done) state_d = (!ctrl_q[0] && !last_line) ? IDLE : NEXT;
      end
      NEXT: begin
        if (!last_line) begin
          line_d  = line_q + 16'd1;
          addr_d  = addr_q + STRIDE32;
          state_d = RD_LVL;
        end else begin
          done_d      = 1'b1;
          frame_irq_d = 1'b1;
          if (pending_q) begin
            front_d   = back_q;
            pending_d = back_wr;
          end
          state_d = ctrl_q[0] ? WAIT_VSYNC : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Master strobes decode straight from the state register, so reset drops them at once.
  always_comb begin
    avm_cfg_address   = '0;
    avm_cfg_write     = 1'b0;
    avm_cfg_read      = 1'b0;
    avm_cfg_writedata = '0;
    case (state_q)
      RD_LVL: begin
        avm_cfg_address = 3'd5;
        avm_cfg_read    = 1'b1;
      end
      WR_ADDR: begin
        avm_cfg_address   = 3'd0;
        avm_cfg_write     = 1'b1;
        avm_cfg_writedata = addr_q;
      end
      WR_LEN: begin
        avm_cfg_address   = 3'd1;
        avm_cfg_write     = 1'b1;
        avm_cfg_writedata = LEN_WORD;
      end
      WR_CTRL: begin
        avm_cfg_address   = 3'd2;
        avm_cfg_write     = 1'b1;
        avm_cfg_writedata = {31'b0, fixed_q};
      end
      WR_START: begin
        avm_cfg_address = 3'd3;
        avm_cfg_write   = 1'b1;
      end
      CLR_IRQ: begin
        avm_cfg_address = 3'd4;
        avm_cfg_write   = 1'b1;
      end
      default: ;
    endcase
  end

  assign avs_ctl_readdata = rdata_q;
  assign frame_irq        = frame_irq_q;

endmodule

// File: tb/tb_vga_line_scheduler.sv
// Directed bench for vga_line_scheduler: a behavioural DMA slave logs every
// accepted master access and the expected sequences are hand-computed.
module tb_vga_line_scheduler;

  localparam int LINES = 6;
  localparam int LB    = 80;
  localparam int TMO   = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  avs_ctl_address = '0;
  logic        avs_ctl_write = 1'b0;
  logic        avs_ctl_read = 1'b0;
  logic [31:0] avs_ctl_writedata = '0;
  logic [31:0] avs_ctl_readdata;
  logic [2:0]  avm_cfg_address;
  logic        avm_cfg_write;
  logic        avm_cfg_read;
  logic [31:0] avm_cfg_writedata;
  logic [31:0] avm_cfg_readdata = '0;
  logic        avm_cfg_waitrequest = 1'b0;
  logic        dma_irq = 1'b0;
  logic        vsync_pulse = 1'b0;
  logic        frame_irq;

  vga_line_scheduler #(
    .LINES(LINES), .LINE_BYTES(LB), .STRIDE(80), .FIFO_DEPTH(4096), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .avs_ctl_address(avs_ctl_address), .avs_ctl_write(avs_ctl_write),
    .avs_ctl_read(avs_ctl_read), .avs_ctl_writedata(avs_ctl_writedata),
    .avs_ctl_readdata(avs_ctl_readdata),
    .avm_cfg_address(avm_cfg_address), .avm_cfg_write(avm_cfg_write),
    .avm_cfg_read(avm_cfg_read), .avm_cfg_writedata(avm_cfg_writedata),
    .avm_cfg_readdata(avm_cfg_readdata), .avm_cfg_waitrequest(avm_cfg_waitrequest),
    .dma_irq(dma_irq), .vsync_pulse(vsync_pulse), .frame_irq(frame_irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // DMA slave model: accesses logged at the negedge before their completing edge.
  int          ev_a[$];
  logic [31:0] ev_d[$];
  int          lvl_q[$];
  int          cyc = 0;
  int          start_cyc = 0, clr_cyc = 0;
  int          fi_cycles = 0, both_hi = 0;
  bit          irq_en = 1'b1;
  int          irq_delay = 3, irq_cnt = -1;
  int          stall_addr = -1, stall_left = 0, stall_seen = 0, stab_ok = 0;
  bit          stall_on = 1'b0;
  logic [2:0]  snap_a = '0;
  logic [31:0] snap_d = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_irq) fi_cycles++;
    if (avm_cfg_read && avm_cfg_write) both_hi++;
    if (irq_cnt > 0) begin
      irq_cnt--;
      if (irq_cnt == 0) begin
        dma_irq = 1'b1;
        irq_cnt = -1;
      end
    end
    if (avm_cfg_write && int'(avm_cfg_address) == stall_addr && stall_left > 0) begin
      if (!stall_on) begin
        snap_a   = avm_cfg_address;
        snap_d   = avm_cfg_writedata;
        stall_on = 1'b1;
      end
      if (avm_cfg_address == snap_a && avm_cfg_writedata == snap_d) stab_ok++;
      stall_left--;
      stall_seen++;
      avm_cfg_waitrequest = 1'b1;
    end else begin
      if (stall_on && avm_cfg_write) begin
        if (avm_cfg_address == snap_a && avm_cfg_writedata == snap_d) stab_ok++;
        stall_on = 1'b0;
      end
      avm_cfg_waitrequest = 1'b0;
    end
    if (!avm_cfg_waitrequest) begin
      if (avm_cfg_write) begin
        ev_a.push_back(int'(avm_cfg_address));
        ev_d.push_back(avm_cfg_writedata);
        if (avm_cfg_address == 3'd3) begin
          start_cyc = cyc;
          if (irq_en) irq_cnt = irq_delay;
        end
        if (avm_cfg_address == 3'd4) begin
          clr_cyc = cyc;
          dma_irq = 1'b0;
        end
      end
      if (avm_cfg_read) begin
        ev_a.push_back(8);
        ev_d.push_back(32'd0);
        avm_cfg_readdata = (lvl_q.size() > 0) ? 32'(lvl_q.pop_front()) : 32'd100;
      end
    end
  end

  task automatic cpu_wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    avs_ctl_address = a; avs_ctl_writedata = d; avs_ctl_write = 1'b1;
    @(posedge clk); #1;
    avs_ctl_write = 1'b0;
  endtask

  task automatic cpu_rd(input logic [1:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    avs_ctl_address = a; avs_ctl_read = 1'b1;
    @(posedge clk); #1;
    avs_ctl_read = 1'b0;
    d = avs_ctl_readdata;
  endtask

  task automatic pulse_vsync();
    @(posedge clk); #1 vsync_pulse = 1'b1;
    @(posedge clk); #1 vsync_pulse = 1'b0;
  endtask

  task automatic wait_ev(input int n, input string tag);
    int k;
    k = 0;
    while (ev_a.size() < n && k < 3000) begin
      @(posedge clk);
      k++;
    end
    check(tag, ev_a.size(), n);
  endtask

  task automatic chk_line(input int idx, input int nrd, input logic [31:0] sa,
                          input logic [31:0] ctl, input string nm);
    logic [31:0] exp_d [5];
    if (ev_a.size() < idx + nrd + 5) begin
      check({nm, " evcount"}, ev_a.size(), idx + nrd + 5);
      return;
    end
    for (int i = 0; i < nrd; i++) check($sformatf("%s rd%0d", nm, i), ev_a[idx+i], 8);
    exp_d = '{sa, 32'(LB - 2), ctl, 32'd0, 32'd0};
    for (int i = 0; i < 5; i++) begin
      check($sformatf("%s addr%0d", nm, i), ev_a[idx+nrd+i], i);
      check($sformatf("%s data%0d", nm, i), ev_d[idx+nrd+i], exp_d[i]);
    end
  endtask

  initial begin
    logic [31:0] rd;
    int base;
    bit found;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_write", avm_cfg_write, 0);
    check("rst_read", avm_cfg_read, 0);
    check("rst_addr", avm_cfg_address, 0);
    check("rst_wdata", avm_cfg_writedata, 0);
    check("rst_frame_irq", frame_irq, 0);
    check("rst_readdata", avs_ctl_readdata, 0);
    @(posedge clk); #1 reset = 1'b0;

    cpu_rd(2'd3, rd); check("status_reset", rd, 32'h0);
    cpu_rd(2'd1, rd); check("front_reset", rd, 32'h0);
    cpu_wr(2'd1, 32'hDEAD_BEEF);
    cpu_rd(2'd1, rd); check("front_readonly", rd, 32'h0);
    cpu_wr(2'd2, 32'h1000);
    cpu_rd(2'd3, rd); check("status_pending", rd, 32'h4);
    cpu_rd(2'd2, rd); check("back_rd", rd, 32'h1000);

    // Frame 0: base 0, no stalls, swap to 0x1000 at end
    cpu_wr(2'd0, 32'h1);
    cpu_rd(2'd0, rd); check("ctrl_rd", rd, 32'h1);
    pulse_vsync();
    wait_ev(6 * LINES, "f0_events");
    repeat (4) @(posedge clk);
    for (int l = 0; l < LINES; l++) chk_line(6 * l, 1, 32'(80 * l), 32'd0, $sformatf("f0_l%0d", l));
    check("f0_frame_irq_cycles", fi_cycles, 1);
    cpu_rd(2'd1, rd); check("f0_front_swapped", rd, 32'h1000);
    cpu_rd(2'd3, rd); check("f0_status", rd, 32'h0005_0001);
    cpu_wr(2'd3, 32'h1);
    cpu_rd(2'd3, rd); check("f0_done_cleared", rd, 32'h0005_0000);

    // Frame 1: FIFO back-pressure, LONGTH stall, mid-frame BACK_BASE, stray vsync
    base = ev_a.size();
    lvl_q = '{4070, 4056, 4055};
    stall_addr = 1; stall_left = 3;
    pulse_vsync();
    wait_ev(base + 14, "f1_line1_events");
    cpu_wr(2'd2, 32'h8000);
    pulse_vsync();
    wait_ev(base + 8 + 6 * (LINES - 1), "f1_events");
    repeat (4) @(posedge clk);
    chk_line(base, 3, 32'h1000, 32'd0, "f1_l0");
    for (int l = 1; l < LINES; l++)
      chk_line(base + 8 + 6 * (l - 1), 1, 32'h1000 + 32'(80 * l), 32'd0, $sformatf("f1_l%0d", l));
    check("stall_cycles", stall_seen, 3);
    check("stall_stable_cycles", stab_ok, 4);
    check("stall_data", snap_d, 32'd78);
    check("f1_frame_irq_cycles", fi_cycles, 2);
    cpu_rd(2'd1, rd); check("f1_front_swapped", rd, 32'h8000);
    cpu_rd(2'd3, rd); check("f1_status", rd, 32'h0005_0001);
    cpu_wr(2'd3, 32'h1);
    stall_addr = -1;

    // Frame 2: fixed mode, timeout on line 0, disable during line 3
    base = ev_a.size();
    cpu_wr(2'd0, 32'h3);
    irq_en = 1'b0;
    irq_delay = 8;
    pulse_vsync();
    wait_ev(base + 6, "f2_timeout_line");
    irq_en = 1'b1;
    check("timeout_latency", clr_cyc - start_cyc, TMO + 1);
    wait_ev(base + 23, "f2_line3_start");
    cpu_wr(2'd0, 32'h0);
    repeat (60) @(posedge clk);
    check("disable_event_count", ev_a.size(), base + 24);
    for (int l = 0; l < 4; l++)
      chk_line(base + 6 * l, 1, 32'h8000 + 32'(80 * l), 32'd1, $sformatf("f2_l%0d", l));
    @(negedge clk);
    check("idle_write", avm_cfg_write, 0);
    check("idle_read", avm_cfg_read, 0);
    check("f2_no_frame_irq", fi_cycles, 2);
    cpu_rd(2'd3, rd); check("f2_status", rd, 32'h0003_0002);
    cpu_wr(2'd3, 32'h2);
    cpu_rd(2'd3, rd); check("tmo_cleared", rd, 32'h0003_0000);

    // Reset during a stalled WR_CTRL
    stall_addr = 2; stall_left = 3;
    cpu_wr(2'd0, 32'h1);
    pulse_vsync();
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (avm_cfg_write && avm_cfg_address == 3'd2) found = 1'b1;
    end
    check("wr_ctrl_seen", found, 1);
    #1 reset = 1'b1;
    #1;
    check("async_rst_write", avm_cfg_write, 0);
    check("async_rst_addr", avm_cfg_address, 0);
    stall_addr = -1; stall_left = 0; stall_on = 1'b0;
    irq_cnt = -1; dma_irq = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cpu_rd(2'd1, rd); check("post_rst_front", rd, 32'h0);
    cpu_rd(2'd0, rd); check("post_rst_ctrl", rd, 32'h0);
    cpu_rd(2'd3, rd); check("post_rst_status", rd, 32'h0);
    check("rd_wr_both_high", both_hi, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/vga_line_scheduler.md
# vga_line_scheduler

Sequences the 1-bit VGA line DMA engine from its Avalon-MM register slave, so the CPU only programs a frame base once. The block polls the DMA's FIFO fill level and programs one display line per transfer: source address, length, mode and start. It waits for the DMA completion interrupt, clears it, and steps to the next line. It swaps front/back frame buffers at frame end and sits between the CPU control bus and the DMA configuration slave.

## Interface
- LINES, 480: display lines per frame.
- LINE_BYTES, 80: bytes per line (640 px at 1 bpp); must be even and ≥ 2.
- STRIDE, 80: byte address increment between lines.
- FIFO_DEPTH, 4096: DMA FIFO depth in 16-bit words.
- TIMEOUT, 65535: cycles to wait for the DMA irq before flagging an error.
- clk  in  1  system clock.
- reset  in  1  reset reset, asynchronous, active-high; clock clk.
- avs_ctl_address  in  2  CPU register select: 0 CTRL, 1 FRONT_BASE, 2 BACK_BASE, 3 STATUS.
- avs_ctl_write / avs_ctl_read  in  1  CPU strobes.
- avs_ctl_writedata  in  32  CPU write data.
- avs_ctl_readdata  out  32  registered read data, valid 1 cycle after read.
- avm_cfg_address  out  3  DMA register word offset: 0 S_ADDR, 1 LONGTH, 2 CONTROL, 3 START, 4 STATUS, 5 WRUSEDW.
- avm_cfg_write / avm_cfg_read  out  1  master strobes.
- avm_cfg_writedata  out  32  master write data.
- avm_cfg_readdata  in  32  DMA read data.
- avm_cfg_waitrequest  in  1  DMA slave stall.
- dma_irq  in  1  DMA line-done interrupt (level).
- vsync_pulse  in  1  one-cycle frame-start pulse, already synchronous to clk.
- frame_irq  out  1  one-cycle pulse at end of each frame.

## Operation
- CTRL: bit0 enable, bit1 fixed-address mode, copied to DMA CONTROL bit0. FRONT_BASE is read-only from the CPU. A write to BACK_BASE sets the internal pending flag. STATUS reads {6'b0, line[9:0], 13'b0, pending, timeout_err, frame_done}. Writing 1 to bit0 clears frame_done; writing 1 to bit1 clears timeout_err.
- FSM states: IDLE, WAIT_VSYNC, RD_LVL, WR_ADDR, WR_LEN, WR_CTRL, WR_START, WAIT_IRQ, CLR_IRQ, NEXT.
  - IDLE → WAIT_VSYNC when enable = 1.
  - WAIT_VSYNC → RD_LVL on vsync_pulse; sets line = 0 and addr = FRONT_BASE.
  - RD_LVL: reads WRUSEDW. If rd + LINE_BYTES/2 > FIFO_DEPTH − 1, it re-reads; otherwise it goes to WR_ADDR.
  - WR_ADDR writes addr. WR_LEN writes LINE_BYTES − 2, because the DMA moves LONGTH/2 + 1 halfwords. WR_CTRL writes {31'b0, CTRL[1]}. WR_START writes 0.
  - WAIT_IRQ → CLR_IRQ when dma_irq = 1. After TIMEOUT cycles it sets timeout_err and goes to CLR_IRQ anyway.
  - CLR_IRQ writes 0 to DMA STATUS, then goes to NEXT.
  - NEXT when line < LINES − 1: line + 1, addr + STRIDE (32-bit, wraps modulo 2^32), → RD_LVL.
  - NEXT when line = LINES − 1: sets frame_done, pulses frame_irq, and swaps FRONT_BASE ← BACK_BASE if pending (then clears pending). Goes → WAIT_VSYNC if enable = 1, else → IDLE.
- Enable cleared mid-frame: the current line completes through CLR_IRQ, then the FSM goes to IDLE. No DMA transfer is ever abandoned.
- A BACK_BASE write in the same cycle as the swap: the swap uses the old BACK_BASE, the new value is stored, and pending stays 1.
- A clear of a STATUS bit in the same cycle as its set: the set wins.
- A vsync_pulse outside WAIT_VSYNC is ignored.

## Timing
- Reset values:
  - all outputs 0;
  - FRONT_BASE, BACK_BASE, CTRL, line, addr all 0;
  - pending and flags 0;
  - state IDLE.
- Master transactions:
  - address, strobe and data are driven from the state register in the cycle the state is entered.
  - They are held stable until the first cycle with avm_cfg_waitrequest = 0; the transaction completes at that edge.
  - The next transaction may start the following cycle.
  - avm_cfg_read and avm_cfg_write are never high together.
- avm_cfg_readdata is sampled on the completing edge of a read.
- Minimum per-line overhead with no stalls: RD_LVL 1 + 4 writes + WAIT_IRQ ≥ 1 + CLR_IRQ 1 + NEXT 1 = 8 cycles.
- frame_irq is high for exactly the one cycle after the NEXT edge at the last line.
- The CPU slave has zero wait states; CPU writes take effect on the next edge.
- Asynchronous reset mid-transaction drops all strobes immediately.

## Test plan
- **Single line, no stalls.** LINES = 2, FRONT_BASE = 0x1000, enable, vsync. Expected writes: S_ADDR 0x1000, LONGTH 78, CONTROL 0, START, then STATUS clear after dma_irq. Line 1 S_ADDR is 0x1050.
- **FIFO back-pressure.** WRUSEDW returns 4070, then 4000. Expected: two reads, and the S_ADDR write follows the second read.
- **Waitrequest.** Hold waitrequest high for 3 cycles on the LONGTH write. Expected: address, data and strobe stable all 4 cycles, with exactly one accepted write.
- **Buffer swap.** Write BACK_BASE = 0x8000 mid-frame. Expected at frame end: frame_irq pulse, FRONT_BASE = 0x8000, pending = 0, and next frame line 0 S_ADDR 0x8000.
- **Timeout.** TIMEOUT = 16 and dma_irq never asserts. Expected: timeout_err = 1 at cycle 16 of WAIT_IRQ, a STATUS clear is issued, and the next line proceeds.
- **Disable and reset.** Clear enable on line 3. Expected: CLR_IRQ completes, the FSM goes to IDLE, and no START is issued. Reset asserted during WR_CTRL drops avm_cfg_write the same cycle.
